// File: rtl/i_decode_pkg.sv
// Shared decode constants, issue opcode enum and decoder state encoding.
package i_decode_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_LUI = 3'd3
  } ex_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2,
    BRANCH = 2'd3
  } state_t;

endpackage

// File: rtl/i_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, x0 never busy.
module i_scoreboard
  import i_decode_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rd1_addr,
  output logic                  rd1_busy_c,
  input  logic [REG_ADDR_W-1:0] rd2_addr,
  output logic                  rd2_busy_c,
  output logic [NUM_REGS-1:0]   busy
);

  localparam logic [NUM_REGS-1:0] X0_MASK = NUM_REGS'(1);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid) set_mask[set_addr] = 1'b1;
    if (clr_valid) clr_mask[clr_addr] = 1'b1;
  end

  // Set is applied after clear so a same-cycle set/clear leaves the bit set.
  always_ff @(posedge clk) begin
    if (!rst) busy <= '0;
    else      busy <= ((busy & ~clr_mask) | set_mask) & ~X0_MASK;
  end

  assign rd1_busy_c = busy[rd1_addr];
  assign rd2_busy_c = busy[rd2_addr];

endmodule

// File: rtl/i_decode.sv
// Single-issue decoder: latches one instruction, checks hazards, issues ALU ops or resolves BNE.
module i_decode
  import i_decode_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  input  logic [INST_WIDTH-1:0] inst,
  output logic                  inst_vacant,
  output logic                  offset_valid,
  output logic [ADDR_WIDTH-1:0] offset,
  output logic [4:0]            rf_rs1_addr,
  output logic [4:0]            rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output ex_op_t                ex_op,
  output logic [4:0]            ex_rd,
  output logic [DATA_WIDTH-1:0] ex_a,
  output logic [DATA_WIDTH-1:0] ex_b
);

  state_t                  state;
  logic [INST_WIDTH-1:0]   inst_q;

  logic [6:0]              opcode;
  logic [2:0]              f3;
  logic [6:0]              f7;
  logic [4:0]              rd_f;
  logic [12:0]             imm_b;
  logic [ADDR_WIDTH-1:0]   imm_b_ext;

  ex_op_t                  dec_op;
  logic [4:0]              dec_rd;
  logic                    use_rs1;
  logic                    use_rs2;
  logic                    is_bne;
  logic [DATA_WIDTH-1:0]   opnd_a;
  logic [DATA_WIDTH-1:0]   opnd_b;
  logic                    hazard;

  logic                    rs1_busy;
  logic                    rs2_busy;
  logic [NUM_REGS-1:0]     busy;

  assign opcode      = inst_q[6:0];
  assign rd_f        = inst_q[11:7];
  assign f3          = inst_q[14:12];
  assign f7          = inst_q[31:25];
  assign rf_rs1_addr = inst_q[19:15];
  assign rf_rs2_addr = inst_q[24:20];
  assign imm_b       = {inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_b_ext   = {{(ADDR_WIDTH-13){imm_b[12]}}, imm_b};

  // Instruction classification and operand selection from the latched word.
  always_comb begin
    dec_op  = OP_NOP;
    dec_rd  = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_bne  = 1'b0;
    opnd_a  = '0;
    opnd_b  = '0;
    if (opcode == OPC_OP_IMM && f3 == F3_ADDI) begin
      dec_op  = OP_ADD;
      dec_rd  = rd_f;
      use_rs1 = 1'b1;
      opnd_a  = rf_rs1_data;
      opnd_b  = {{(DATA_WIDTH-12){inst_q[31]}}, inst_q[31:20]};
    end else if (opcode == OPC_OP && f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) begin
      dec_op  = (f7 == F7_SUB) ? OP_SUB : OP_ADD;
      dec_rd  = rd_f;
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
      opnd_a  = rf_rs1_data;
      opnd_b  = rf_rs2_data;
    end else if (opcode == OPC_LUI) begin
      dec_op  = OP_LUI;
      dec_rd  = rd_f;
      opnd_b  = DATA_WIDTH'({inst_q[31:12], 12'b0});
    end else if (opcode == OPC_BRANCH && f3 == F3_BNE) begin
      is_bne  = 1'b1;
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
    end
  end

  // dec_rd is zero for BNE/NOP and busy[0] is never set, so rd=0 needs no special case.
  assign hazard = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy) || busy[dec_rd];

  i_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_valid  (state == ISSUE && ex_ready),
    .set_addr   (ex_rd),
    .clr_valid  (wb_valid),
    .clr_addr   (wb_rd),
    .rd1_addr   (rf_rs1_addr),
    .rd1_busy_c (rs1_busy),
    .rd2_addr   (rf_rs2_addr),
    .rd2_busy_c (rs2_busy),
    .busy       (busy)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      inst_q       <= '0;
      inst_vacant  <= 1'b1;
      offset_valid <= 1'b0;
      offset       <= '0;
      ex_valid     <= 1'b0;
      ex_op        <= OP_NOP;
      ex_rd        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
    end else begin
      offset_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_valid) begin
            inst_q      <= inst;
            inst_vacant <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (!hazard) begin
            if (is_bne) begin
              offset_valid <= 1'b1;
              offset       <= (rf_rs1_data != rf_rs2_data) ? imm_b_ext - ADDR_WIDTH'(4) : '0;
              state        <= BRANCH;
            end else begin
              ex_valid <= 1'b1;
              ex_op    <= dec_op;
              ex_rd    <= dec_rd;
              ex_a     <= opnd_a;
              ex_b     <= opnd_b;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (ex_ready) begin
            ex_valid    <= 1'b0;
            inst_vacant <= 1'b1;
            state       <= IDLE;
          end
        end
        BRANCH: begin
          inst_vacant <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          inst_vacant <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/i_decode.md
I_DECODE -- requirements
Module: i_decode

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address and offset width; INST_WIDTH, default 32, instruction width; DATA_WIDTH, default 32, operand width.
REQ-002 SHALL have ports, one per line, with these exact names, directions, widths and meanings:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- inst_valid  in  1  one-cycle pulse from fetch: inst is valid.
- inst  in  INST_WIDTH  instruction word from fetch.
- inst_vacant  out  1  decoder can accept an instruction.
- offset_valid  out  1  one-cycle pulse: BNE resolved.
- offset  out  ADDR_WIDTH  PC adjustment relative to BNE address + 4.
- rf_rs1_addr, rf_rs2_addr  out  5 each  register-file read addresses.
- rf_rs1_data, rf_rs2_data  in  DATA_WIDTH each  combinational read data.
- wb_valid  in  1  writeback of register wb_rd this cycle.
- wb_rd  in  5  writeback destination.
- ex_valid  out  1  issue request to execute.
- ex_ready  in  1  execute accepts the issue.
- ex_op  out  3  operation code (package enum).
- ex_rd  out  5  destination register.
- ex_a, ex_b  out  DATA_WIDTH each  operands.

Function
REQ-003 SHALL implement states IDLE, DECODE, ISSUE, BRANCH; inst_vacant SHALL be 1 exactly in IDLE.
REQ-004 IDLE: SHALL latch inst into an internal register on inst_valid=1 and go to DECODE; inst_valid outside IDLE SHALL be ignored.
REQ-005 SHALL decode: ADDI (opcode 0010011, f3 000), ADD/SUB (0110011, f3 000, f7 0000000/0100000), LUI (0110111), BNE (1100011, f3 001); any other encoding SHALL become OP_NOP with ex_rd=0.
REQ-006 SHALL keep a 32-bit busy scoreboard; bit 0 SHALL read as 0 at all times.
REQ-007 DECODE: SHALL stall while any used source (rs1 for ADDI/ADD/SUB/BNE; rs2 for ADD/SUB/BNE) or rd (non-BNE, rd≠0) is busy, checking registered busy bits only (no bypass).
REQ-008 DECODE with no hazard: BNE SHALL go to BRANCH; all others SHALL capture operands into ex_a/ex_b and go to ISSUE.
REQ-009 Operands SHALL be: ADDI a=rs1, b=sext(imm_i); ADD/SUB a=rs1, b=rs2; LUI a=0, b={imm[31:12],12'b0}; NOP a=b=0.
REQ-010 ISSUE: ex_valid=1 with ex_op/ex_rd/ex_a/ex_b held stable until ex_ready=1; on acceptance SHALL set busy[rd] (rd≠0), drop ex_valid next cycle and return to IDLE.
REQ-011 BRANCH: SHALL pulse offset_valid for exactly one cycle with offset = (rs1≠rs2) ? sext(imm_b)−4 : 0, computed mod 2^ADDR_WIDTH, then return to IDLE; BNE SHALL never assert ex_valid.
REQ-012 wb_valid=1 SHALL clear busy[wb_rd]; a same-cycle set and clear of the same register SHALL leave it set.
REQ-013 Latency, no hazards: inst_valid to ex_valid = 2 cycles; inst_valid to offset_valid = 2 cycles.
REQ-014 rf_rs1_addr/rf_rs2_addr SHALL be driven combinationally from the latched instruction fields.

Reset
REQ-015 rst=0 SHALL force state IDLE, busy=0, ex_valid=0, offset_valid=0, offset=0, ex_op=OP_NOP, ex_rd=0, ex_a=ex_b=0; inst_vacant SHALL read 1 in the first cycle after release.
REQ-016 Reset in any state, including mid-ISSUE, SHALL drop any in-flight instruction without setting busy bits.

Structure
REQ-017 A shared package SHALL hold the opcode/funct constants, the ex_op enum (OP_NOP, OP_ADD, OP_SUB, OP_LUI) and the state encoding.
REQ-018 Scoreboard SHALL be a sub-module, i_scoreboard (set port, clear port, two read ports).

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- ADDI x1,x0,5 with ex_ready=1 -> ex_op=OP_ADD, ex_rd=1, ex_a=0, ex_b=5 two cycles after inst_valid; busy[1]=1.
- ADD x2,x1,x1 while busy[1]=1; wb_valid, wb_rd=1 after 3 cycles -> ex_valid stays 0 until the cycle after the clear.
- BNE x1,x2,+16 with rs1=3, rs2=4 -> one offset_valid pulse, offset=12; with rs1=rs2=7 -> offset=0; ex_valid never 1.
- BNE with imm_b=−8 -> offset=0xFFFFFFF4.
- ex_ready held 0 for 5 cycles -> ex_* stable, inst_vacant=0, busy[rd] set only on acceptance.
- rst=0 mid-ISSUE -> all outputs at REQ-015 values, busy=0, next instruction accepted normally.
